// File: rtl/chip.sv
// Audio data path: I2S receiver or BIST ramp -> stereo-pair FIFO -> I2S master transmitter.
// Sticky overrun/underrun status with software clear pulses.
module chip #(
  parameter int WORD_W           = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int CYC_PER_HALF_SCK = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inp_sck,
  input  logic        inp_ws,
  input  logic        inp_sd,
  input  logic        rf_i2si_en,
  input  logic [11:0] rf_bist_start_val,
  input  logic [7:0]  rf_bist_inc,
  input  logic [11:0] rf_bist_up_limit,
  input  logic        rf_mux_en,
  output logic        i2so_sck,
  output logic        i2so_ws,
  output logic        i2so_sd,
  input  logic        trig_fifo_overrun_clr,
  output logic        ro_fifo_overrun,
  input  logic        trig_fifo_underrun,
  output logic        ro_fifo_underrun,
  output logic        filt_rtr
);
  localparam int DW   = 2 * WORD_W;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(WORD_W) + 1;
  localparam int SLW  = $clog2(DW);
  localparam int DIVW = $clog2(CYC_PER_HALF_SCK);

  // ---------------- receiver input conditioning ----------------
  logic [1:0] r_sck_s, r_ws_s, r_sd_s;
  logic       r_sck_d;
  logic       w_sck_fall, w_rx_ws, w_rx_sd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s <= '0;
      r_ws_s  <= '0;
      r_sd_s  <= '0;
      r_sck_d <= 1'b0;
    end else begin
      r_sck_s <= {r_sck_s[0], inp_sck};
      r_ws_s  <= {r_ws_s[0], inp_ws};
      r_sd_s  <= {r_sd_s[0], inp_sd};
      r_sck_d <= r_sck_s[1];
    end
  end

  assign w_sck_fall = r_sck_d & ~r_sck_s[1];
  assign w_rx_ws    = r_ws_s[1];
  assign w_rx_sd    = r_sd_s[1];

  // ---------------- receiver framing ----------------
  logic              r_ws_prev, r_rx_armed, r_rx_ch, r_l_valid;
  logic [CW-1:0]     r_rx_cnt;
  logic [WORD_W-2:0] r_rx_sh;
  logic [WORD_W-1:0] r_l_word;
  logic [WORD_W-1:0] w_rx_word;
  logic              w_ws_chg, w_rx_shift, w_rx_done, w_rx_wr;

  assign w_ws_chg   = w_rx_ws != r_ws_prev;
  assign w_rx_shift = r_rx_armed && (r_rx_cnt < CW'(WORD_W));
  assign w_rx_word  = {r_rx_sh, w_rx_sd};
  assign w_rx_done  = w_sck_fall && rf_i2si_en && w_rx_shift && (r_rx_cnt == CW'(WORD_W - 1));
  assign w_rx_wr    = w_rx_done && r_rx_ch && r_l_valid;

  // A ws change sample carries the LSB of the old word; the restart below overrides the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ws_prev  <= 1'b0;
      r_rx_armed <= 1'b0;
      r_rx_ch    <= 1'b0;
      r_l_valid  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_sh    <= '0;
      r_l_word   <= '0;
    end else begin
      if (w_sck_fall) r_ws_prev <= w_rx_ws;
      if (!rf_i2si_en) begin
        r_rx_armed <= 1'b0;
        r_rx_ch    <= 1'b0;
        r_l_valid  <= 1'b0;
        r_rx_cnt   <= '0;
        r_rx_sh    <= '0;
      end else if (w_sck_fall) begin
        if (w_rx_shift) begin
          r_rx_sh  <= w_rx_word[WORD_W-2:0];
          r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        if (w_rx_done) begin
          if (!r_rx_ch) begin
            r_l_word  <= w_rx_word;
            r_l_valid <= 1'b1;
          end else begin
            r_l_valid <= 1'b0;
          end
        end
        if (w_ws_chg) begin
          r_rx_armed <= 1'b1;
          r_rx_cnt   <= '0;
          r_rx_ch    <= w_rx_ws;
        end
      end
    end
  end

  // ---------------- BIST ramp ----------------
  logic        r_bist_run;
  logic [11:0] r_bist_val;
  logic [11:0] w_bist_val, w_bist_next;
  logic [12:0] w_bist_sum;

  assign w_bist_val  = r_bist_run ? r_bist_val : rf_bist_start_val;
  assign w_bist_sum  = {1'b0, w_bist_val} + 13'(rf_bist_inc);
  assign w_bist_next = (w_bist_sum[12] || (w_bist_sum[11:0] > rf_bist_up_limit))
                       ? rf_bist_start_val : w_bist_sum[11:0];

  // ---------------- FIFO ----------------
  // Handshake: a write transfers only in a cycle where the source is valid and
  // filt_rtr (not full) is high; a pop transfers only at a frame start with the FIFO non-empty.
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic          w_full, w_empty, w_wr_req, w_wr, w_pop;
  logic [DW-1:0] w_wr_data, w_rd_data;

  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_empty   = r_wp == r_rp;
  assign w_wr_req  = rf_mux_en ? 1'b1 : w_rx_wr;
  assign w_wr      = w_wr_req && !w_full;
  assign w_wr_data = rf_mux_en
                     ? {{(WORD_W-12){1'b0}}, w_bist_val, {(WORD_W-12){1'b0}}, w_bist_val}
                     : {r_l_word, w_rx_word};
  assign w_rd_data = r_mem[r_rp[AW-1:0]];
  assign filt_rtr  = !w_full;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_bist_run <= 1'b0;
      r_bist_val <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      if (!rf_mux_en) begin
        r_bist_run <= 1'b0;
      end else if (w_wr) begin
        r_bist_run <= 1'b1;
        r_bist_val <= w_bist_next;
      end
    end
  end

  // ---------------- transmitter ----------------
  logic [DIVW-1:0] r_div;
  logic [SLW-1:0]  r_slot;
  logic [DW-1:0]   r_pair;
  logic            r_sck, r_ws, r_sd, r_popped;
  logic            w_tick, w_tx_fall, w_frame_start, w_ws_n;
  logic [SLW-1:0]  w_slot_n;

  assign w_tick        = r_div == DIVW'(CYC_PER_HALF_SCK - 1);
  assign w_tx_fall     = w_tick && r_sck;
  assign w_slot_n      = r_slot + SLW'(1);
  // ws carries the channel of the following slot, so it leads each MSB by one bit.
  assign w_ws_n        = (w_slot_n >= SLW'(WORD_W - 1)) && (w_slot_n != '1);
  assign w_frame_start = w_tx_fall && (w_slot_n == '1);
  assign w_pop         = w_frame_start && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_sck    <= 1'b0;
      r_ws     <= 1'b0;
      r_sd     <= 1'b0;
      r_slot   <= '1;
      r_pair   <= '0;
      r_popped <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIVW'(1);
      if (w_tick) r_sck <= ~r_sck;
      if (w_tx_fall) begin
        r_slot <= w_slot_n;
        r_ws   <= w_ws_n;
        r_sd   <= r_pair[~w_slot_n];
      end
      if (w_frame_start) r_pair <= w_empty ? '0 : w_rd_data;
      if (w_pop) r_popped <= 1'b1;
    end
  end

  assign i2so_sck = r_sck;
  assign i2so_ws  = r_ws;
  assign i2so_sd  = r_sd;

  // ---------------- sticky status ----------------
  logic r_ovr, r_udr;
  logic w_ovr_set, w_udr_set;

  assign w_ovr_set = !rf_mux_en && w_rx_wr && w_full;
  assign w_udr_set = w_frame_start && w_empty && r_popped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr <= 1'b0;
      r_udr <= 1'b0;
    end else begin
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (trig_fifo_overrun_clr) r_ovr <= 1'b0;
      if (w_udr_set) r_udr <= 1'b1;
      else if (trig_fifo_underrun) r_udr <= 1'b0;
    end
  end

  assign ro_fifo_overrun  = r_ovr;
  assign ro_fifo_underrun = r_udr;
endmodule

// File: tb/tb_chip.sv
// Directed bench for chip: drives an I2S source, decodes the I2S output into
// {L,R} frames and compares them against an expected queue.
module tb_chip;
  localparam int HALF  = 8;
  localparam int FRAME = 64 * HALF;

  logic        clk = 1'b0;
  logic        rst;
  logic        inp_sck, inp_ws, inp_sd, rf_i2si_en, rf_mux_en;
  logic [11:0] rf_bist_start_val, rf_bist_up_limit;
  logic [7:0]  rf_bist_inc;
  logic        trig_fifo_overrun_clr, trig_fifo_underrun;
  logic        i2so_sck, i2so_ws, i2so_sd;
  logic        ro_fifo_overrun, ro_fifo_underrun, filt_rtr;

  chip #(.WORD_W(16), .FIFO_DEPTH(8), .CYC_PER_HALF_SCK(HALF)) dut (
    .clk(clk), .rst(rst),
    .inp_sck(inp_sck), .inp_ws(inp_ws), .inp_sd(inp_sd),
    .rf_i2si_en(rf_i2si_en),
    .rf_bist_start_val(rf_bist_start_val), .rf_bist_inc(rf_bist_inc),
    .rf_bist_up_limit(rf_bist_up_limit), .rf_mux_en(rf_mux_en),
    .i2so_sck(i2so_sck), .i2so_ws(i2so_ws), .i2so_sd(i2so_sd),
    .trig_fifo_overrun_clr(trig_fifo_overrun_clr), .ro_fifo_overrun(ro_fifo_overrun),
    .trig_fifo_underrun(trig_fifo_underrun), .ro_fifo_underrun(ro_fifo_underrun),
    .filt_rtr(filt_rtr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] mon_sh = '0;
  logic        mon_ws_d = 1'b0;
  logic        mon_started = 1'b0;
  logic        saw_full = 1'b0;
  logic [15:0] src_l[32];
  logic [15:0] src_r[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output decoder: the sample where ws falls is the right LSB, closing a frame.
  always @(posedge i2so_sck) begin
    mon_sh = {mon_sh[30:0], i2so_sd};
    if (mon_ws_d && !i2so_ws && (mon_started || mon_sh != 32'h0)) begin
      rx_q.push_back(mon_sh);
      mon_started = 1'b1;
    end
    mon_ws_d = i2so_ws;
  end

  always @(negedge clk) if (!rst && !filt_rtr) saw_full = 1'b1;

  task automatic mon_clear();
    rx_q.delete();
    mon_sh      = '0;
    mon_ws_d    = 1'b0;
    mon_started = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_clear();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic src_slot(input logic ws, input logic sd, input int h);
    inp_sck = 1'b1;
    inp_ws  = ws;
    inp_sd  = sd;
    repeat (h) @(negedge clk);
    inp_sck = 1'b0;
    repeat (h) @(negedge clk);
  endtask

  task automatic send_pairs(input int n, input int h);
    logic [15:0] w;
    logic        ch;
    src_slot(1'b1, 1'b0, h);
    src_slot(1'b0, 1'b0, h);
    for (int j = 0; j < 2 * n; j++) begin
      ch = j[0];
      w  = ch ? src_r[j/2] : src_l[j/2];
      for (int i = 15; i >= 0; i--) src_slot((i == 0) ? ~ch : ch, w[i], h);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count_ok"}, 32'(rx_q.size() >= exp_q.size()), 32'd1);
    for (int k = 0; k < exp_q.size(); k++)
      if (k < rx_q.size()) check($sformatf("%s[%0d]", tag, k), rx_q[k], exp_q[k]);
  endtask

  task automatic pulse(input logic which_ovr);
    if (which_ovr) trig_fifo_overrun_clr = 1'b1;
    else trig_fifo_underrun = 1'b1;
    @(negedge clk);
    trig_fifo_overrun_clr = 1'b0;
    trig_fifo_underrun    = 1'b0;
  endtask

  initial begin
    logic found;
    inp_sck = 0; inp_ws = 0; inp_sd = 0;
    rf_i2si_en = 0; rf_mux_en = 0;
    rf_bist_start_val = 12'd1; rf_bist_inc = 8'd1; rf_bist_up_limit = 12'd25;
    trig_fifo_overrun_clr = 0; trig_fifo_underrun = 0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(i2so_sck), 32'd0);
    check("rst_ws", 32'(i2so_ws), 32'd0);
    check("rst_sd", 32'(i2so_sd), 32'd0);
    check("rst_ovr", 32'(ro_fifo_overrun), 32'd0);
    check("rst_udr", 32'(ro_fifo_underrun), 32'd0);
    check("rst_rtr", 32'(filt_rtr), 32'd1);

    // I2S pass-through
    rf_i2si_en = 1'b1;
    do_reset();
    src_l[0] = 16'h1234; src_r[0] = 16'hABCD;
    src_l[1] = 16'h8001; src_r[1] = 16'h7FFE;
    src_l[2] = 16'hFFFF; src_r[2] = 16'h0001;
    src_l[3] = 16'h5A5A; src_r[3] = 16'hA5A5;
    for (int k = 0; k < 4; k++) exp_q.push_back({src_l[k], src_r[k]});
    send_pairs(4, HALF);
    wait_frames(4, 6 * FRAME);
    check_frames("pass");
    check("pass_ovr", 32'(ro_fifo_overrun), 32'd0);

    // BIST ramp 1..25
    rf_mux_en = 1'b1;
    rf_bist_start_val = 12'd1; rf_bist_inc = 8'd1; rf_bist_up_limit = 12'd25;
    do_reset();
    for (int v = 1; v <= 25; v++) exp_q.push_back({16'(v), 16'(v)});
    exp_q.push_back({16'd1, 16'd1});
    exp_q.push_back({16'd2, 16'd2});
    wait_frames(27, 30 * FRAME);
    check_frames("bist1");
    check("bist1_rtr", 32'(filt_rtr), 32'd0);
    check("bist1_ovr", 32'(ro_fifo_overrun), 32'd0);

    // BIST ramp start 3, inc 4, limit 20
    rf_bist_start_val = 12'd3; rf_bist_inc = 8'd4; rf_bist_up_limit = 12'd20;
    do_reset();
    exp_q.push_back({16'd3, 16'd3});
    exp_q.push_back({16'd7, 16'd7});
    exp_q.push_back({16'd11, 16'd11});
    exp_q.push_back({16'd15, 16'd15});
    exp_q.push_back({16'd19, 16'd19});
    exp_q.push_back({16'd3, 16'd3});
    exp_q.push_back({16'd7, 16'd7});
    wait_frames(7, 10 * FRAME);
    check_frames("bist2");

    // overrun: source twice as fast as the output
    rf_mux_en = 1'b0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      src_l[k] = 16'h1000 + 16'(k);
      src_r[k] = 16'h2000 + 16'(k);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({src_l[k], src_r[k]});
    saw_full = 1'b0;
    send_pairs(32, HALF / 2);
    check("ovr_saw_full", 32'(saw_full), 32'd1);
    check("ovr_set", 32'(ro_fifo_overrun), 32'd1);
    check_frames("ovr_order");
    repeat (20) @(negedge clk);
    pulse(1'b1);
    check("ovr_clr", 32'(ro_fifo_overrun), 32'd0);

    // underrun
    do_reset();
    repeat (3 * FRAME) @(negedge clk);
    check("udr_prepop", 32'(ro_fifo_underrun), 32'd0);
    src_l[0] = 16'hA1B2; src_r[0] = 16'hC3D4;
    src_l[1] = 16'h0F0F; src_r[1] = 16'hF0F0;
    exp_q.push_back({src_l[0], src_r[0]});
    exp_q.push_back({src_l[1], src_r[1]});
    exp_q.push_back(32'h0);
    send_pairs(2, HALF);
    wait_frames(3, 6 * FRAME);
    check_frames("udr");
    check("udr_set", 32'(ro_fifo_underrun), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      logic ws_prev;
      ws_prev = i2so_ws;
      @(negedge clk);
      if (ws_prev && !i2so_ws) begin
        found = 1'b1;
        break;
      end
    end
    check("udr_align", 32'(found), 32'd1);
    repeat (10) @(negedge clk);
    pulse(1'b0);
    check("udr_clr", 32'(ro_fifo_underrun), 32'd0);

    // receiver disabled: nothing reaches the FIFO
    rf_i2si_en = 1'b0;
    do_reset();
    send_pairs(2, HALF);
    repeat (3 * FRAME) @(negedge clk);
    check("dis_frames", 32'(rx_q.size()), 32'd0);
    check("dis_rtr", 32'(filt_rtr), 32'd1);

    // reset mid-frame while BIST keeps the FIFO full
    rf_mux_en = 1'b1;
    do_reset();
    repeat (2 * FRAME + 300) @(negedge clk);
    rst = 1'b1;
    rf_mux_en = 1'b0;
    @(negedge clk);
    check("mid_sck", 32'(i2so_sck), 32'd0);
    check("mid_ws", 32'(i2so_ws), 32'd0);
    check("mid_sd", 32'(i2so_sd), 32'd0);
    check("mid_rtr", 32'(filt_rtr), 32'd1);
    check("mid_ovr", 32'(ro_fifo_overrun), 32'd0);
    check("mid_udr", 32'(ro_fifo_underrun), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_clear();
    repeat (3 * FRAME + 100) @(negedge clk);
    check("mid_empty_frames", 32'(rx_q.size()), 32'd0);
    check("mid_no_udr", 32'(ro_fifo_underrun), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
